// File: rtl/lb_arb_pkg.sv
// Shared constants and types for the local-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lb_arb_pkg;

   localparam int LB_AW       = 24;
   localparam int LB_DW       = 32;
   localparam int LB_READ_DEL = 3;

   // Which master launched a bus transaction.
   typedef enum logic {
      SRC_HOST  = 1'b0,
      SRC_LOCAL = 1'b1
   } src_e;

   // One slot of the read-return tag pipeline.
   typedef struct packed {
      logic valid;
      src_e src;
   } tag_t;

endpackage

// File: rtl/lb_arbiter_if.sv
// Signal bundle for the arbiter: host port, local-master port and the shared local bus.
// Latency: n/a (wires only).
// Backpressure: host has none; local master uses level req / pulsed ack.
interface lb_arbiter_if
   import lb_arb_pkg::*;
#(
   parameter int AW    = LB_AW,
   parameter int DW    = LB_DW,
   parameter int CNT_W = 16
);

   // host (packet gateway) side
   logic          h_strobe;
   logic          h_rd;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_dout;
   logic [DW-1:0] h_din;

   // local sequencer side
   logic          m_req;
   logic          m_rd;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_dout;
   logic          m_ack;
   logic [DW-1:0] m_din;
   logic          m_din_valid;

   // shared local bus toward the register fabric
   logic          lb_strobe;
   logic          lb_rd;
   logic [AW-1:0] lb_addr;
   logic [DW-1:0] lb_dout;
   logic [DW-1:0] lb_din;

   logic [CNT_W-1:0] m_stall_cnt;

   // arbiter side
   modport slave (
      input  h_strobe, h_rd, h_addr, h_dout,
      output h_din,
      input  m_req, m_rd, m_addr, m_dout,
      output m_ack, m_din, m_din_valid,
      output lb_strobe, lb_rd, lb_addr, lb_dout,
      input  lb_din,
      output m_stall_cnt
   );

   // environment side: both masters plus the register fabric
   modport master (
      output h_strobe, h_rd, h_addr, h_dout,
      input  h_din,
      output m_req, m_rd, m_addr, m_dout,
      input  m_ack, m_din, m_din_valid,
      input  lb_strobe, lb_rd, lb_addr, lb_dout,
      output lb_din,
      input  m_stall_cnt
   );

endinterface

// File: rtl/lb_tag_pipe.sv
// Shift register of {valid, src} tags that follows each bus transaction to its read return.
// Latency: DEPTH cycles from tag_in to tag_out.
// Backpressure: none; advances every cycle, synchronous clear on rst.
module lb_tag_pipe
   import lb_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stage_q [DEPTH];

   // Shift tags one stage per cycle; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/lb_arbiter.sv
// Shares one local bus between the packet gateway (host) and an on-chip sequencer (local).
// Latency: 1 cycle request-to-lb_strobe; local read data READ_DEL+1 cycles after lb_strobe.
// Backpressure: host never stalled and always wins; local req held until m_ack, max 1 per 2 cycles.
module lb_arbiter
   import lb_arb_pkg::*;
#(
   parameter int AW       = LB_AW,
   parameter int DW       = LB_DW,
   parameter int READ_DEL = LB_READ_DEL,
   parameter int CNT_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   lb_arbiter_if.slave bus
);

   logic          grant;
   logic          issue;
   logic          nxt_rd;
   logic [AW-1:0] nxt_addr;
   logic [DW-1:0] nxt_dout;
   tag_t          tag_in;
   tag_t          tag_out;

   logic             lb_strobe_q;
   logic             lb_rd_q;
   logic [AW-1:0]    lb_addr_q;
   logic [DW-1:0]    lb_dout_q;
   logic             m_ack_q;
   logic             m_din_valid_q;
   logic [DW-1:0]    m_din_q;
   logic [CNT_W-1:0] stall_q;

   // Pick this cycle's bus owner: host first, local only on a free cycle that is not
   // the ack cycle of its previous grant (the master still shows stale fields then).
   always_comb begin
      grant         = bus.m_req & ~bus.h_strobe & ~m_ack_q;
      issue         = bus.h_strobe | grant;
      nxt_rd        = 1'b0;
      nxt_addr      = lb_addr_q;
      nxt_dout      = lb_dout_q;
      tag_in.valid  = 1'b0;
      tag_in.src    = SRC_HOST;
      if (bus.h_strobe) begin
         nxt_rd       = bus.h_rd;
         nxt_addr     = bus.h_addr;
         nxt_dout     = bus.h_dout;
         tag_in.valid = bus.h_rd;
         tag_in.src   = SRC_HOST;
      end else if (grant) begin
         nxt_rd       = bus.m_rd;
         nxt_addr     = bus.m_addr;
         nxt_dout     = bus.m_dout;
         tag_in.valid = bus.m_rd;
         tag_in.src   = SRC_LOCAL;
      end
   end

   // Register the bus outputs and the local ack; address/data hold between transactions.
   always_ff @(posedge clk) begin
      if (rst) begin
         lb_strobe_q <= 1'b0;
         lb_rd_q     <= 1'b0;
         lb_addr_q   <= '0;
         lb_dout_q   <= '0;
         m_ack_q     <= 1'b0;
      end else begin
         lb_strobe_q <= issue;
         lb_rd_q     <= nxt_rd;
         lb_addr_q   <= nxt_addr;
         lb_dout_q   <= nxt_dout;
         m_ack_q     <= grant;
      end
   end

   // Count cycles where the host pre-empted a pending local request; sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (bus.m_req && bus.h_strobe && !(&stall_q)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   // Stage 0 of the pipe lines up with lb_strobe, so the last of READ_DEL+1 stages
   // coincides with lb_din being valid for that transaction.
   lb_tag_pipe #(
      .DEPTH (READ_DEL + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Capture read data for local reads only; host reads see lb_din directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_din_valid_q <= 1'b0;
         m_din_q       <= '0;
      end else begin
         m_din_valid_q <= tag_out.valid && (tag_out.src == SRC_LOCAL);
         if (tag_out.valid && (tag_out.src == SRC_LOCAL)) begin
            m_din_q <= bus.lb_din;
         end
      end
   end

   assign bus.lb_strobe   = lb_strobe_q;
   assign bus.lb_rd       = lb_rd_q;
   assign bus.lb_addr     = lb_addr_q;
   assign bus.lb_dout     = lb_dout_q;
   assign bus.m_ack       = m_ack_q;
   assign bus.m_din       = m_din_q;
   assign bus.m_din_valid = m_din_valid_q;
   assign bus.m_stall_cnt = stall_q;
   assign bus.h_din       = bus.lb_din;

endmodule

// File: doc/lb_arbiter.md
Name: lb_arbiter

Overview:
- Shares one local bus (addr/data/strobe/rd, fixed read latency) between two masters.
- Host master: the UDP packet gateway. It has no back-pressure and always wins.
- Local master: an on-chip sequencer (e.g. boot-time register loader). It uses a req/ack handshake and only gets idle bus cycles.
- Sits between the gateway's local-bus output and the register decode fabric. Routes read data back to the master that issued each read.

Parameters:
AW, 24, local-bus address width
DW, 32, local-bus data width
READ_DEL, 3, cycles from lb_strobe asserted to lb_din valid at the register fabric
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  single design clock
rst  in  1  synchronous reset, active-high
h_strobe  in  1  host transaction strobe, one-cycle pulse, never stalled
h_rd  in  1  host read(1)/write(0), valid with h_strobe
h_addr  in  AW  host address, valid with h_strobe
h_dout  in  DW  host write data, valid with h_strobe
h_din  out  DW  read data returned to host
m_req  in  1  local request; level, held with fields stable until m_ack
m_rd  in  1  local read(1)/write(0)
m_addr  in  AW  local address
m_dout  in  DW  local write data
m_ack  out  1  one-cycle pulse: local request issued on lb this cycle
m_din  out  DW  read data returned to local master
m_din_valid  out  1  one-cycle pulse qualifying m_din
lb_strobe  out  1  bus transaction strobe
lb_rd  out  1  bus read/write
lb_addr  out  AW  bus address
lb_dout  out  DW  bus write data
lb_din  in  DW  bus read data, valid READ_DEL cycles after lb_strobe
m_stall_cnt  out  CNT_W  count of cycles m_req was pending but blocked by host

Behaviour:
- Reset values: lb_strobe=0, lb_rd=0, lb_addr=0, lb_dout=0, m_ack=0, m_din_valid=0, m_stall_cnt=0. Tag pipeline is cleared.
- All lb_* outputs are registered. Accept decision in cycle t gives lb_strobe in cycle t+1.
- Host path:
  - h_strobe at t gives lb_strobe=1 at t+1, with lb_rd/addr/dout taken from h_* sampled at t.
  - Host-visible read latency is READ_DEL+1 cycles from h_strobe; the gateway's pipe_del is set accordingly.
  - h_din is lb_din passed through combinationally, with no gating.
- Local grant, cycle t: grant = m_req & ~h_strobe & ~m_ack_next_pending, where m_ack_next_pending is a local grant made in cycle t-1.
  - Granted: lb_* at t+1 carry m_*, and m_ack=1 at t+1.
  - The master may deassert or change fields in the cycle after m_ack.
  - Maximum local rate is one transaction per 2 cycles.
- Host precedence: h_strobe and m_req in the same cycle always issue the host transaction. The local request stays pending, with no m_ack.
- Bus issue rule: at most one lb_strobe per cycle, from exactly one source.
- Tag pipeline:
  - Depth READ_DEL+1, registered.
  - Each stage holds {valid, src}.
  - Entry pushed at issue: valid = lb_rd & lb_strobe, src = HOST or LOCAL.
  - When the output stage has valid & src==LOCAL: m_din_valid=1 and m_din=lb_din (registered, so m_din_valid is asserted READ_DEL+1 cycles after lb_strobe).
  - Host reads produce no m_din_valid.
- Writes: no tag entry, no m_din_valid. m_ack is the only completion indication for local writes.
- m_stall_cnt: increments by 1 in every cycle with m_req & h_strobe. Saturates at all-ones and does not wrap. Cleared only by rst.
- Reset mid-operation: in-flight tags are discarded, and no m_din_valid is issued for reads launched before rst. A h_strobe or m_req coinciding with rst is dropped (no lb_strobe, no m_ack).
- Starvation: the host strobes at most once per 8 cycles, so a pending local request is granted within 2 cycles. This is not enforced in RTL; the bench checks it as an assertion.

Decomposition:
- Package lb_arb_pkg: constants LB_AW=24, LB_DW=32, LB_READ_DEL=3; source encoding SRC_HOST=1'b0, SRC_LOCAL=1'b1.
- One sub-module: lb_tag_pipe (parameterised-depth shift register of {valid, src} with synchronous clear).

Test Plan:
- Host write h_addr=0x000010, h_dout=0xDEADBEEF at t=5 -> lb_strobe=1, lb_addr=0x000010, lb_dout=0xDEADBEEF, lb_rd=0 at t=6; m_ack stays 0.
- Local read m_addr=0x000123, bus model returns 0xCAFEF00D -> m_ack at t+1, m_din_valid=1 with m_din=0xCAFEF00D at t+1+READ_DEL+1=t+5; exactly one pulse.
- m_req held while h_strobe pulses at the same cycle -> host issued first, m_ack one cycle later, m_stall_cnt=1.
- m_req held continuously, no host traffic -> lb_strobe every 2nd cycle, m_ack pulses alternate; 10 local reads return 10 m_din_valid in order with correct data.
- Interleaved host read at t and local read at t+2 -> h_din=lb_din at t+1+READ_DEL; m_din_valid only for the local tag; no cross-delivery.
- Local read issued, rst asserted 1 cycle later for 2 cycles -> all lb_* and m_* outputs reset, m_din_valid never asserts, m_stall_cnt=0.
